// File: rtl/print_uart_tx.sv
// Print-port UART transmitter: buffers 32-bit words pushed by the core and
// sends each word as 4 bytes (LSB byte first), 8N1, LSB bit first.
// Ports: clk; start (async active-low reset); print_en/print_data push;
//        tx serial line; busy, fifo_full, overflow (sticky), fifo_count.
module print_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        start,
  input  logic                        print_en,
  input  logic [31:0]                 print_data,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shift_q, shift_d;
  logic          tx_q, tx_d;

  logic push, pop, baud_end;

  // Fullness uses the registered count, so a push while full is dropped
  // even when the FSM pops in the same cycle.
  assign push     = print_en && (cnt_q != DEPTH);
  assign pop      = (state_q == S_IDLE) && (cnt_q != '0);
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // tx_d is derived from the state being entered so the registered
  // line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop) begin
          shift_d = mem_q[rptr_q];
          byte_d  = 2'd0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[{byte_q, 3'd0}];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[{byte_q, bit_q + 3'd1}];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (print_en && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= print_data;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (cnt_q != '0);
  assign fifo_full  = (cnt_q == DEPTH);
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// Self-checking bench for print_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Compares the tx waveform cycle-by-cycle against hand-built frames.
module tb_print_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        print_en = 1'b0;
  logic [31:0] print_data = '0;
  logic        tx, busy, fifo_full, overflow;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic [31:0] order;
  } vec_t;

  vec_t tbl[5];

  print_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .start     (start),
    .print_en  (print_en),
    .print_data(print_data),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    print_en   = 1'b1;
    print_data = d;
    @(posedge clk);
    #1 print_en = 1'b0;
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  // order holds the bytes in transmission order, first byte in [31:24]
  task automatic add_word(input logic [31:0] order);
    logic [7:0] by;
    for (int b = 0; b < 4; b++) begin
      by = order[31-8*b -: 8];
      repeat (CPB) exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) exp_q.push_back(by[j]);
      end
      repeat (CPB) exp_q.push_back(1'b1);
    end
  endtask

  task automatic capture(input string name);
    int first;
    int n;
    logic got;
    first = -1;
    got   = 1'b0;
    n     = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== exp_q[i] && first < 0) begin
        first = i;
        got   = tx;
      end
    end
    checks++;
    if (first >= 0) begin
      errors++;
      $display("FAIL %s: tx at cycle %0d got %b expected %b",
               name, first, got, exp_q[first]);
    end
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    logic bad;
    tbl[0] = '{32'h000000C3, 32'hC3000000};
    tbl[1] = '{32'h44332211, 32'h11223344};
    tbl[2] = '{32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[3] = '{32'h0000FFFF, 32'hFFFF0000};
    tbl[4] = '{32'h80000001, 32'h01000080};

    // reset state
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", fifo_count, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);

    // back-to-back words: one idle cycle between them
    push(32'hA5A5A5A5);
    push(32'h0000FFFF);
    add_word(32'hA5A5A5A5);
    add_idle(1);
    add_word(32'hFFFF0000);
    capture("b2b_stream");
    @(posedge clk);
    #1;
    chk("b2b_busy", busy, 0);
    chk("b2b_tx", tx, 1);

    // overflow: six pushes into a depth-4 FIFO
    for (int k = 0; k < 6; k++) begin
      push(32'(k));
      if (k == 4) begin
        chk("ovf_cnt4", fifo_count, 4);
        chk("ovf_full4", fifo_full, 1);
        chk("ovf_flag4", overflow, 0);
      end
      if (k == 5) begin
        chk("ovf_cnt5", fifo_count, 4);
        chk("ovf_full5", fifo_full, 1);
        chk("ovf_flag5", overflow, 1);
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (k != 0) add_idle(1);
      add_word(32'(k) << 24);
    end
    repeat (4) void'(exp_q.pop_front());
    capture("ovf_stream");
    @(posedge clk);
    #1;
    chk("ovf_busy", busy, 0);
    chk("ovf_sticky", overflow, 1);

    // push on the pop edge while full
    start = 1'b0;
    #1;
    chk("sp_rst_ovf", overflow, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) push(32'h100 + 32'(k));
    chk("sp_cnt4", fifo_count, 4);
    repeat (157) @(posedge clk);
    #1;
    chk("sp_idle_cnt", fifo_count, 4);
    chk("sp_idle_tx", tx, 1);
    push(32'hDEAD0000);
    chk("sp_pop_cnt", fifo_count, 3);
    chk("sp_pop_ovf", overflow, 1);
    chk("sp_pop_tx", tx, 0);
    push(32'hBEEF0001);
    chk("sp_next_cnt", fifo_count, 4);
    chk("sp_next_ovf", overflow, 1);
    wait_idle("sp_drain", 3000);

    // reset during DATA of byte 1
    push(32'h44332211);
    push(32'h55555555);
    repeat (45) @(posedge clk);
    #1;
    chk("ab_pre_tx", tx, 0);
    chk("ab_pre_cnt", fifo_count, 1);
    start = 1'b0;
    #1;
    chk("ab_tx", tx, 1);
    chk("ab_busy", busy, 0);
    chk("ab_cnt", fifo_count, 0);
    chk("ab_ovf", overflow, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);

    // table of single words
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].data);
      add_idle(1);
      add_word(tbl[i].order);
      capture($sformatf("vec%0d_stream", i));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), busy, 0);
      chk($sformatf("vec%0d_tx", i), tx, 1);
      chk($sformatf("vec%0d_cnt", i), fifo_count, 0);
    end

    // long idle with data toggling but no strobe
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      print_data = $urandom;
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad = 1'b1;
    end
    chk("idle_1000", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/print_uart_tx.md
Name: print_uart_tx

Overview:
- Consumer end of the core's print interface: accepts 32-bit words pulsed on print_en/print_data and serializes them on a UART TX line, 8N1, LSB first.
- Sits beside riscv_cpu_core at the top level; output drives the board UART pin.
- Each word is buffered in a FIFO so that core print bursts do not stall or lose data until the FIFO fills.
- Each word is sent as 4 bytes, least-significant byte first.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
FIFO_DEPTH, 16, word entries in the print FIFO; power of two, >= 2

Ports:
clk  input  1  system clock, rising-edge
start  input  1  asynchronous active-low reset; low clears all state immediately
print_en  input  1  single-cycle push strobe from core
print_data  input  32  word to print, sampled when print_en=1
tx  output  1  UART serial line, idle high
busy  output  1  1 while FIFO non-empty or FSM not IDLE
fifo_full  output  1  1 when fifo_count == FIFO_DEPTH
overflow  output  1  sticky: a push was dropped because FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (start=0, async): tx=1, busy=0, fifo_full=0, overflow=0, fifo_count=0, FSM=IDLE.
  - FIFO pointers, bit counter, baud counter and byte index all cleared.
  - Reset mid-frame aborts the frame: tx goes high without waiting for a clock edge. Buffered words are discarded.
- FIFO push rule: print_en=1 and fifo_count < FIFO_DEPTH -> write print_data at the write pointer and increment the pointer.
  - Fullness is judged on the registered count before this cycle's pop.
  - A push while full is dropped, even if a pop occurs in the same cycle. The drop sets overflow=1, which holds until reset.
- Simultaneous push and pop: fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- print_data while print_en=0 is ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1.
    - If fifo_count != 0: pop the head word into a 32-bit shift register, byte_idx=0, go to START.
    - Pop latency: a word pushed at edge N is popped at edge N+1 when the FIFO was empty. tx falls on edge N+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = shift_reg[byte_idx*8 + bit_idx], each bit held CLKS_PER_BIT cycles.
    - After bit_idx=7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<3: increment byte_idx, go to START directly, with no extra idle cycle between bytes of one word.
    - Else go to IDLE.
- Frame timing:
  - One byte = 10*CLKS_PER_BIT cycles.
  - One word = 40*CLKS_PER_BIT cycles.
  - Back-to-back words have exactly 1 idle-high clock (the IDLE pop cycle) between the stop bit of byte 3 and the next start bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; it is reset on every state entry.
- tx is driven from a register (glitch-free).
- busy is combinational from the registered state: (state != IDLE) || (fifo_count != 0).
- fifo_full is combinational from fifo_count.

Test Plan:
- CLKS_PER_BIT=4; push 0x44332211 at edge N:
  - tx=0 from edge N+1 for 4 cycles, then bits of 0x11 LSB first, stop, then 0x22, 0x33, 0x44.
  - Total 160 cycles from N+1.
  - busy=0 and tx=1 after.
- Push 0xA5A5A5A5 then 0x0000FFFF on consecutive edges:
  - Decoded byte stream: A5,A5,A5,A5,FF,FF,00,00.
  - Exactly 1 idle-high cycle between the words; no idle cycles between bytes within a word.
- FIFO_DEPTH=4; push words 0..5 on 6 consecutive edges:
  - word0 popped at edge N+1.
  - fifo_count reaches 4 at edge N+4; word5 is dropped.
  - overflow=1 and fifo_full=1 at that point.
  - Transmitted words are 0..4 only.
- At fifo_count=4 with the FSM in STOP of byte 3:
  - A push on the pop edge is dropped, overflow=1, and fifo_count ends at 3.
  - A push on the following edge is accepted, and fifo_count ends at 4.
- Assert start=0 during DATA of byte 1:
  - tx=1 immediately; busy=0, fifo_count=0, overflow=0.
  - After release, a new push of 0x000000C3 transmits C3,00,00,00 cleanly from a START state.
- Idle with print_en=0 for 1000 cycles: tx stays 1, busy stays 0, no FIFO change.
